crc32_k_frame_checker: RTL

Receive-side companion to the CRC32_K byte-serial CRC generator. Accepts a frame byte-by-byte whose last four bytes are the transmitter's CRC32_K, MSB byte first. It runs the same CRC32_K (Koopman, polynomial 0x741B8CD7, MSB-first, no final XOR) over the whole frame, CRC bytes included, and declares the frame good when the residue is zero. It sits between the byte receiver (UART/deframer) and the packet consumer, and also reports frame length and overrun.

---
 rtl/crc32_k_frame_checker.sv | 128 ++++++++++++
 1 files changed

// File: rtl/crc32_k_frame_checker.sv
// ---------------------------------------------------------------------------
// crc32_k_frame_checker : byte-serial CRC32_K (Koopman) receive-side checker
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module crc32_k_frame_checker #(
   parameter logic [31:0] INITIAL_STATES = 32'h0000_0000,
   parameter logic [15:0] MAX_COUNT      = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_Init,
   input  logic        i_RX_En,
   input  logic [7:0]  i_RX_Byte,
   input  logic        i_EOF,
   output logic        o_Busy,
   output logic        o_Byte_Ready,
   output logic        o_Frame_Done,
   output logic        o_CRC_OK,
   output logic        o_Len_Err,
   output logic        o_Overrun,
   output logic [15:0] o_Byte_Count,
   output logic [31:0] o_Residue
);

   localparam logic [31:0] C_POLY    = 32'h741B_8CD7;
   localparam logic [15:0] C_MIN_LEN = 16'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] crc;
   logic [7:0]  shreg;
   logic [2:0]  bit_cnt;
   logic        eof_lat;
   logic        fb;
   logic [31:0] crc_next;
   logic [15:0] count_inc;

   // One MSB-first step of the CRC32_K LFSR, fed from the top of the byte shifter.
   assign fb        = crc[31] ^ shreg[7];
   assign crc_next  = {crc[30:0], 1'b0} ^ (fb ? C_POLY : 32'h0000_0000);
   assign count_inc = (o_Byte_Count == MAX_COUNT) ? o_Byte_Count : o_Byte_Count + 16'd1;
   assign o_Residue = crc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         crc          <= INITIAL_STATES;
         shreg        <= 8'h00;
         bit_cnt      <= 3'd0;
         eof_lat      <= 1'b0;
         o_Byte_Count <= 16'd0;
         o_Busy       <= 1'b0;
         o_Byte_Ready <= 1'b0;
         o_Frame_Done <= 1'b0;
         o_CRC_OK     <= 1'b0;
         o_Len_Err    <= 1'b0;
         o_Overrun    <= 1'b0;
      end else begin
         o_Byte_Ready <= 1'b0;
         o_Frame_Done <= 1'b0;
         if (i_Init) begin
            // Wins over a same-cycle strobe: that byte is silently dropped.
            state        <= IDLE;
            crc          <= INITIAL_STATES;
            o_Byte_Count <= 16'd0;
            o_Busy       <= 1'b0;
            o_CRC_OK     <= 1'b0;
            o_Len_Err    <= 1'b0;
            o_Overrun    <= 1'b0;
         end else begin
            if (i_RX_En && (state != IDLE)) begin
               o_Overrun <= 1'b1;
            end
            case (state)
               IDLE: begin
                  if (i_RX_En) begin
                     shreg        <= i_RX_Byte;
                     eof_lat      <= i_EOF;
                     o_Byte_Count <= count_inc;
                     bit_cnt      <= 3'd7;
                     o_Busy       <= 1'b1;
                     state        <= SHIFT;
                  end
               end
               SHIFT: begin
                  crc     <= crc_next;
                  shreg   <= {shreg[6:0], 1'b0};
                  bit_cnt <= bit_cnt - 3'd1;
                  if (bit_cnt == 3'd0) begin
                     o_Byte_Ready <= 1'b1;
                     if (eof_lat) begin
                        state <= CHECK;
                     end else begin
                        o_Busy <= 1'b0;
                        state  <= IDLE;
                     end
                  end
               end
               CHECK: begin
                  o_Len_Err    <= (o_Byte_Count < C_MIN_LEN);
                  o_CRC_OK     <= (crc == 32'h0000_0000) && (o_Byte_Count >= C_MIN_LEN);
                  o_Frame_Done <= 1'b1;
                  state        <= DONE;
               end
               DONE: begin
                  o_Busy <= 1'b0;
                  state  <= IDLE;
               end
               default: begin
                  o_Busy <= 1'b0;
                  state  <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire
